// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types and helpers for the parametrised LIFO stack.
//   stack_op_e : operation that will be applied on the next rising edge.
//   cnt_w      : width of an occupancy counter that can hold 0..depth.
//   decode_op  : maps Clr/Push/Pop/Empty onto a stack_op_e.
// -----------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_CLEAR   = 3'd4
  } stack_op_e;

  // Counter width able to represent every value 0..depth inclusive.
  // A depth of 256 needs 9 bits, which the older 8-bit pointer lacked.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Clear wins over everything. Push+Pop on a non-empty stack overwrites
  // the top entry; on an empty stack there is nothing to replace, so it
  // degenerates into a plain push. Full/Empty error handling is left to
  // the caller because it depends on Full as well.
  function automatic stack_op_e decode_op(input logic clr,
                                          input logic push,
                                          input logic pop,
                                          input logic empty);
    stack_op_e op;
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLEAR;
    end else if (push && pop && !empty) begin
      op = OP_REPLACE;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end
    return op;
  endfunction

endpackage : stack_pkg

// File: rtl/stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// WIDTH x DEPTH storage array: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//
// Ports:
//   clk    in   1                 rising-edge write clock
//   we     in   1                 write enable
//   waddr  in   $clog2(DEPTH)     write index
//   wdata  in   WIDTH             write data
//   raddr  in   $clog2(DEPTH)     read index
//   rdata  out  WIDTH             mem[raddr], or 0 for an index past DEPTH-1
// -----------------------------------------------------------------------------
module stack_mem #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // One extra bit so DEPTH itself is representable for the range checks.
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             waddr_ok;
  logic             raddr_ok;

  // With a non-power-of-two DEPTH the index space has holes above DEPTH-1.
  // The top level never targets them, but the guards keep every access
  // inside the array regardless.
  assign waddr_ok = ({1'b0, waddr} < DEPTH_C);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_C);

  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = raddr_ok ? mem[raddr] : '0;

endmodule : stack_mem

// File: rtl/stack_param.sv
// -----------------------------------------------------------------------------
// stack_param
// Parametrised LIFO stack with replace-top, synchronous clear, occupancy
// count, almost-full flag and sticky overflow/underflow flags.
//
// Ports:
//   clk         in   1                rising-edge clock
//   rst         in   1                asynchronous active-high reset
//   Clr         in   1                synchronous clear (empties, clears flags)
//   Push        in   1                push request
//   Pop         in   1                pop request
//   Din         in   WIDTH            data to push or to replace the top with
//   Top         out  WIDTH            current top-of-stack word, 0 when empty
//   Count       out  cnt_w(DEPTH)     number of valid entries, 0..DEPTH
//   Full        out  1                Count == DEPTH
//   Empty       out  1                Count == 0
//   AlmostFull  out  1                Count >= AF_LEVEL
//   Overflow    out  1                sticky: push attempted while full
//   Underflow   out  1                sticky: pop attempted while empty
//
// Request semantics: Push/Pop are single-cycle requests sampled on every
// rising edge; there is no ready/backpressure. A request that cannot be
// honoured (push when full, pop when empty) is dropped and recorded in the
// matching sticky flag. Push+Pop together replaces the top word (or pushes
// onto an empty stack) and is always legal. Clr overrides both requests.
// -----------------------------------------------------------------------------
module stack_param
  import stack_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Clr,
  input  logic                      Push,
  input  logic                      Pop,
  input  logic [WIDTH-1:0]          Din,
  output logic [WIDTH-1:0]          Top,
  output logic [cnt_w(DEPTH)-1:0]   Count,
  output logic                      Full,
  output logic                      Empty,
  output logic                      AlmostFull,
  output logic                      Overflow,
  output logic                      Underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          unf_q;
  logic          unf_d;

  // ---------------------------------------------------------------------------
  // Decodes of the current count
  // ---------------------------------------------------------------------------
  logic          full;
  logic          empty;
  logic [CW-1:0] count_m1;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;
  stack_op_e     op;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Write index for a push is Count; the top entry lives at Count-1. Both
  // are truncated to the array index width. When full, push_idx aliases a
  // low entry but is never used because the push is rejected. When empty,
  // top_idx is all-ones but Top is forced to zero in that case.
  assign count_m1 = count_q - ONE_C;
  assign push_idx = count_q[AW-1:0];
  assign top_idx  = count_m1[AW-1:0];

  assign op = decode_op(Clr, Push, Pop, empty);

  // ---------------------------------------------------------------------------
  // Memory write port controls
  // ---------------------------------------------------------------------------
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_rdata;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = push_idx;

    case (op)
      OP_CLEAR: begin
        count_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end

      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = push_idx;
          count_d   = count_q + ONE_C;
        end
      end

      OP_POP: begin
        // Popped entries are left in place; only the count moves.
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_m1;
        end
      end

      OP_REPLACE: begin
        // Only reachable when non-empty, so top_idx is a valid entry.
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end

      default: begin
        // OP_HOLD: keep everything.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (Din),
    .raddr (top_idx),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs: pure functions of registered state, so Push/Pop/Din never
  // reach an output combinationally. Masking Top with empty also hides the
  // unreset memory contents.
  // ---------------------------------------------------------------------------
  assign Top        = empty ? '0 : mem_rdata;
  assign Count      = count_q;
  assign Full       = full;
  assign Empty      = empty;
  assign AlmostFull = (count_q >= AF_C);
  assign Overflow   = ovf_q;
  assign Underflow  = unf_q;

endmodule : stack_param
